// File: rtl/apu_pkg.sv
// Shared APU definitions: frame counter width, default step counts and sequencer mode encoding.
package apu_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned STEP1_DEF = 7457;
  localparam int unsigned STEP2_DEF = 14913;
  localparam int unsigned STEP3_DEF = 22371;
  localparam int unsigned STEP4_DEF = 29829;
  localparam int unsigned STEP5_DEF = 37281;

  typedef logic [CNT_W-1:0] frame_cnt_t;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_e;

  // Count at which the current sequence wraps back to zero.
  function automatic frame_cnt_t last_step(frame_mode_e mode, frame_cnt_t s4, frame_cnt_t s5);
    return (mode == MODE_5STEP) ? s5 : s4;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// APU frame sequencer: free-running step counter with a registered step decoder.
// Frame IRQ logic is built only when FRAME_IRQ_EN is defined; otherwise irq is tied low.
module frame_counter
  import apu_pkg::*;
#(
  parameter int unsigned STEP1 = STEP1_DEF,
  parameter int unsigned STEP2 = STEP2_DEF,
  parameter int unsigned STEP3 = STEP3_DEF,
  parameter int unsigned STEP4 = STEP4_DEF,
  parameter int unsigned STEP5 = STEP5_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       rd_4015,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       irq
);

  localparam frame_cnt_t S1 = frame_cnt_t'(STEP1);
  localparam frame_cnt_t S2 = frame_cnt_t'(STEP2);
  localparam frame_cnt_t S3 = frame_cnt_t'(STEP3);
  localparam frame_cnt_t S4 = frame_cnt_t'(STEP4);
  localparam frame_cnt_t S5 = frame_cnt_t'(STEP5);

  frame_cnt_t  cnt_q, cnt_d;
  frame_cnt_t  last;
  frame_mode_e mode_q;
  logic        quarter_q, half_q;
  logic        hit_last, hit_quarter, hit_half;

  always_comb begin
    last        = last_step(mode_q, S4, S5);
    hit_last    = (cnt_q == last);
    hit_quarter = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || hit_last;
    hit_half    = (cnt_q == S2) || hit_last;
    cnt_d       = hit_last ? '0 : cnt_q + frame_cnt_t'(1);
  end

  // A write restarts the sequence and masks any step match on the same cycle;
  // entering 5-step mode fires an immediate quarter+half clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      mode_q    <= MODE_4STEP;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else if (wr_4017) begin
      cnt_q     <= '0;
      mode_q    <= frame_mode_e'(wr_data[7]);
      quarter_q <= wr_data[7];
      half_q    <= wr_data[7];
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= hit_quarter;
      half_q    <= hit_half;
    end
  end

  assign quarter_frame = quarter_q;
  assign half_frame    = half_q;

`ifdef FRAME_IRQ_EN
  localparam frame_cnt_t S4M1 = frame_cnt_t'(STEP4 - 1);

  logic       inhibit_q, irq_q, wrap_q;
  logic       irq_set;
  logic [5:0] unused_data;

  assign unused_data = wr_data[5:0];

  // The flag is raised over the last two counts of a 4-step frame and the first
  // count after a natural wrap, so a status read landing in that window cannot lose it.
  always_comb begin
    irq_set = (mode_q == MODE_4STEP) && !inhibit_q &&
              ((cnt_q == S4M1) || (cnt_q == S4) || wrap_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (wr_4017) begin
      inhibit_q <= wr_data[6];
      irq_q     <= irq_q && !rd_4015 && !wr_data[6];
      wrap_q    <= 1'b0;
    end else begin
      irq_q     <= irq_set || (irq_q && !rd_4015);
      wrap_q    <= (mode_q == MODE_4STEP) && (cnt_q == S4);
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_in;

  assign unused_irq_in = ^{rd_4015, wr_data[6:0]};
  assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_frame_counter.sv
// Bench for frame_counter: a default-parameter instance and a short-step instance, both checked
// every cycle against a frame-position model, plus directed boundary checks.
module tb_frame_counter;

  localparam int unsigned S1 = 37;
  localparam int unsigned S2 = 75;
  localparam int unsigned S3 = 112;
  localparam int unsigned S4 = 150;
  localparam int unsigned S5 = 187;

`ifdef FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  // Default instance: reset in ticks 0-1, full 4-step frame, then 0x80 write (+ status read).
  localparam int W_TICK   = 29834;
  localparam int END_TICK = W_TICK + 1 + 37282 + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst, d_wr, d_rd;
  logic [7:0] d_data;
  logic       d_q, d_h, d_irq;
  logic       s_rst, s_wr, s_rd;
  logic [7:0] s_data;
  logic       s_q, s_h, s_irq;

  frame_counter u_def (
    .clk           (clk),
    .rst           (d_rst),
    .wr_4017       (d_wr),
    .wr_data       (d_data),
    .rd_4015       (d_rd),
    .quarter_frame (d_q),
    .half_frame    (d_h),
    .irq           (d_irq)
  );

  frame_counter #(
    .STEP1 (S1),
    .STEP2 (S2),
    .STEP3 (S3),
    .STEP4 (S4),
    .STEP5 (S5)
  ) u_small (
    .clk           (clk),
    .rst           (s_rst),
    .wr_4017       (s_wr),
    .wr_data       (s_data),
    .rd_4015       (s_rd),
    .quarter_frame (s_q),
    .half_frame    (s_h),
    .irq           (s_irq)
  );

  int checks   = 0;
  int failures = 0;
  int tick_n   = 0;

  // Model state per instance (0 = default steps, 1 = short steps).
  int st[2][5];
  int pos[2];
  bit mode5[2], inh[2], irq_m[2], nat[2], eq[2], eh[2];

  int dq1[$], dh1[$], dq2[$], dh2[$];
  int d_irq_first = -1;
  int d_irq_p2    = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s tick=%0d: observed %b expected %b", tag, tick_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pos = cycles into the current frame; nat = frame began by a natural 4-step wrap.
  task automatic model_step(input int i, input logic r, input logic w, input logic [7:0] d,
                            input logic rd);
    int last;
    last = mode5[i] ? st[i][4] : st[i][3];
    if (r) begin
      pos[i] = 0; mode5[i] = 0; inh[i] = 0; irq_m[i] = 0; nat[i] = 0; eq[i] = 0; eh[i] = 0;
    end else if (w) begin
      eq[i] = d[7]; eh[i] = d[7]; mode5[i] = d[7]; pos[i] = 0; nat[i] = 0;
      if (IRQ_ON) begin
        inh[i] = d[6];
        if (d[6] || rd) irq_m[i] = 0;
      end
    end else begin
      eq[i] = (pos[i] == st[i][0]) || (pos[i] == st[i][1]) || (pos[i] == st[i][2]) ||
              (pos[i] == last);
      eh[i] = (pos[i] == st[i][1]) || (pos[i] == last);
      if (IRQ_ON)
        irq_m[i] = (!mode5[i] && !inh[i] && ((pos[i] >= st[i][3] - 1) || (pos[i] == 0 && nat[i])))
                   || (irq_m[i] && !rd);
      if (pos[i] == last) begin
        pos[i] = 0;
        nat[i] = !mode5[i];
      end else begin
        pos[i]++;
        nat[i] = 0;
      end
    end
  endtask

  task automatic tick();
    d_rst  = (tick_n < 2);
    d_wr   = (tick_n == W_TICK);
    d_rd   = (tick_n == W_TICK);
    d_data = 8'h80;
    model_step(0, d_rst, d_wr, d_data, d_rd);
    model_step(1, s_rst, s_wr, s_data, s_rd);
    @(posedge clk);
    #1;
    check("def.quarter", d_q, eq[0]);
    check("def.half", d_h, eh[0]);
    check("def.irq", d_irq, irq_m[0]);
    check("small.quarter", s_q, eq[1]);
    check("small.half", s_h, eh[1]);
    check("small.irq", s_irq, irq_m[1]);
    if (tick_n >= 2 && tick_n < W_TICK) begin
      if (d_q) dq1.push_back(tick_n - 2);
      if (d_h) dh1.push_back(tick_n - 2);
      if (d_irq && d_irq_first < 0) d_irq_first = tick_n - 2;
    end else if (tick_n >= W_TICK) begin
      if (d_q) dq2.push_back(tick_n - W_TICK - 1);
      if (d_h) dh2.push_back(tick_n - W_TICK - 1);
      if (d_irq) d_irq_p2++;
    end
    tick_n++;
    s_rst = 1'b0;
    s_wr  = 1'b0;
    s_rd  = 1'b0;
  endtask

  task automatic run_to(input int p);
    int n;
    n = 0;
    while (pos[1] != p && n < 400) begin
      tick();
      n++;
    end
    if (pos[1] != p) begin
      failures++;
      $display("FAIL run_to: position %0d not reached (at %0d)", p, pos[1]);
    end
  endtask

  task automatic check_queue(input string tag, input int q[$], input int exp[$]);
    check_int({tag, ".count"}, q.size(), exp.size());
    for (int j = 0; j < exp.size(); j++)
      check_int(tag, (j < q.size()) ? q[j] : -99, exp[j]);
  endtask

  initial begin
    st[0] = '{7457, 14913, 22371, 29829, 37281};
    st[1] = '{S1, S2, S3, S4, S5};
    s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_data = 8'h00;
    d_rst = 1'b1; d_wr = 1'b0; d_rd = 1'b0; d_data = 8'h00;

    s_rst = 1'b1; tick();
    s_rst = 1'b1; tick();
    check("reset.quarter", s_q, 1'b0);
    check("reset.half", s_h, 1'b0);
    check("reset.irq", s_irq, 1'b0);

    // Status read coinciding with the set window, then a clearing read.
    run_to(S4); s_rd = 1'b1; tick();
    check("rd_at_last.irq", s_irq, IRQ_ON);
    check("last4.quarter", s_q, 1'b1);
    check("last4.half", s_h, 1'b1);
    s_rd = 1'b1; tick();
    check("rd_at_wrap.irq", s_irq, IRQ_ON);
    s_rd = 1'b1; tick();
    check("rd_clear.irq", s_irq, 1'b0);

    // Inhibit write clears a pending flag and keeps it clear for a whole frame.
    run_to(S4); tick(); tick();
    check("irq_set.irq", s_irq, IRQ_ON);
    run_to(3); s_wr = 1'b1; s_data = 8'h40; tick();
    check("inhibit_clear.irq", s_irq, 1'b0);
    repeat (S4 + 10) tick();
    check("inhibit_frame.irq", s_irq, 1'b0);

    // Write landing on a step match: write wins, counter restarts.
    run_to(S2); s_wr = 1'b1; s_data = 8'h00; tick();
    check("wr_at_step.quarter", s_q, 1'b0);
    check("wr_at_step.half", s_h, 1'b0);
    repeat (S1) tick();
    check("after_wr_early.quarter", s_q, 1'b0);
    tick();
    check("after_wr.quarter", s_q, 1'b1);

    // 5-step mode entry and sequence.
    s_wr = 1'b1; s_data = 8'h80; tick();
    check("mode5_wr.quarter", s_q, 1'b1);
    check("mode5_wr.half", s_h, 1'b1);
    run_to(S4); tick();
    check("mode5_s4.quarter", s_q, 1'b0);
    check("mode5_s4.half", s_h, 1'b0);
    run_to(S5); tick();
    check("mode5_last.quarter", s_q, 1'b1);
    check("mode5_last.half", s_h, 1'b1);
    check("mode5.irq", s_irq, 1'b0);

    // Reset exactly on a step match aborts the pulse and returns to 4-step mode.
    run_to(S1); s_rst = 1'b1; tick();
    check("rst_at_step.quarter", s_q, 1'b0);
    check("rst_at_step.half", s_h, 1'b0);
    check("rst_at_step.irq", s_irq, 1'b0);
    repeat (S1) tick();
    check("after_rst_early.quarter", s_q, 1'b0);
    tick();
    check("after_rst.quarter", s_q, 1'b1);
    run_to(S4); tick();
    check("rst_mode4.quarter", s_q, 1'b1);
    check("rst_mode4.half", s_h, 1'b1);

    // Random traffic on the short instance while the default instance finishes its frames.
    while (tick_n < END_TICK) begin
      s_rst  = ($urandom_range(0, 1999) == 0);
      s_wr   = ($urandom_range(0, 399) == 0);
      s_data = 8'($urandom);
      s_rd   = ($urandom_range(0, 15) == 0);
      tick();
    end

    check_queue("def4.quarter_counts", dq1, '{7457, 14913, 22371, 29829});
    check_queue("def4.half_counts", dh1, '{14913, 29829});
    check_int("def4.irq_first", d_irq_first, IRQ_ON ? 29828 : -1);
    check_queue("def5.quarter_counts", dq2, '{-1, 7457, 14913, 22371, 37281});
    check_queue("def5.half_counts", dh2, '{-1, 14913, 37281});
    check_int("def5.irq_cycles", d_irq_p2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
